ring_rr_arbiter: RTL and testbench
==================================

# ring_rr_arbiter

Round-robin arbiter sharing one resource among N requesters. Priority is a one-hot token in a rotating ring register, advanced like a ring counter past each winner. Sits in front of shared datapath blocks, such as the ring/Johnson counters and shift registers, wherever several masters must take turns. Grants are registered and held while the owner keeps requesting. An optional hold limit forces rotation.

## Interface
- N, 6, number of requesters (2..16)
- HOLD_MAX, 8, max consecutive grant cycles per owner when timeout is compiled in (2..255)
- IW, $clog2(N), index width (derived, not overridden)

- clk  in  1  clock; all state changes on posedge
- reset  in  1  reset, synchronous, active-high
- req  in  N  request vector; req[i] high = requester i wants or keeps the resource
- gnt  out  N  one-hot grant, registered; all-zero when idle
- gnt_valid  out  1  OR of gnt, registered
- gnt_idx  out  IW  index of current owner; 0 when idle
- ptr  out  N  one-hot priority token; bit set = highest-priority requester
- preempt  out  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- Reset values: gnt=0, gnt_valid=0, gnt_idx=0, ptr=1 (bit 0), preempt=0, hold count=0, state IDLE.
- States:
  - IDLE: no owner.
  - OWNED: exactly one gnt bit set.
- Winner search: scan from the ptr bit upward with wrap-around (i, i+1, …, N-1, 0, …, i-1). The first set req bit wins. Implement as a double-width masked priority encode or an equivalent scan, fully combinational.
- IDLE → OWNED: req≠0 at an edge. gnt is set to the winner k and ptr is rotated to bit (k+1) mod N.
- IDLE → IDLE: req=0. ptr is unchanged.
- OWNED, req[owner]=1: hold the grant. No ptr change. Other requests are ignored, except by timeout.
- OWNED, req[owner]=0, another req pending: hand over at the same edge to the winner searched from the current ptr. ptr becomes winner+1. No idle gap.
- OWNED, req[owner]=0, req=0: → IDLE, gnt=0.
- The owner is always lowest priority after winning, because ptr has already moved past it. Fairness: each pending requester is granted within N-1 handovers.
- req bits of non-owners may toggle freely. Only the value sampled at the edge matters.
- Reset mid-grant: next edge forces all reset values regardless of req.

## Timing
- Request to grant latency: 1 cycle (req sampled at edge t, gnt visible after edge t).
- Release to next grant: 0 idle cycles. The edge that samples req[owner]=0 installs the next winner.
- gnt, gnt_valid, gnt_idx and ptr all update on the same edge and are always mutually consistent.
- Grant is never issued to a requester whose req was low at the deciding edge.

## Configuration
- Macro: RING_RR_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on each new grant and increments each cycle the owner holds.
  - When the count reaches HOLD_MAX-1 and another req bit is set, the next edge hands over to the winner as in a normal release, and preempt pulses high for that one cycle.
  - With no competitor, the owner keeps the grant and the counter saturates at HOLD_MAX-1.
  - The preempted owner re-enters arbitration normally.
- Undefined: no counter. The owner holds indefinitely while req[owner]=1. preempt is tied 0. HOLD_MAX is unused.

## Test plan
- Reset: assert reset 2 cycles with req=6'b111111 → gnt=0, gnt_valid=0, ptr=6'b000001, preempt=0.
- Single requester: req=6'b001000 → next cycle gnt=6'b001000, gnt_idx=3, ptr=6'b010000. Drop req → next cycle gnt=0, ptr stays 6'b010000.
- Full contention: req=6'b111111; each owner drops its bit for one cycle after its grant → grant order 0,1,2,3,4,5,0 with no idle cycles between grants.
- Wrap-around: after a grant to 4 (ptr=6'b100000), release with req=6'b000101 → gnt=6'b000001, ptr=6'b000010.
- Timeout (macro on, HOLD_MAX=4): req=6'b000101 held → gnt bit0 for 4 cycles, then bit2 for 4 cycles, alternating. preempt pulses once at each switch. With the macro off, bit0 is held forever.
- Reset mid-grant: owner 2 holding and reset asserted for 1 cycle → gnt=0, ptr=6'b000001. With req=6'b000100 kept high, gnt returns to bit2 one cycle after reset deasserts.

Source files
------------

// File: rtl/ring_rr_arbiter_if.sv
// ring_rr_arbiter_if: request/grant bundle between requesters (master) and the round-robin arbiter (slave)
interface ring_rr_arbiter_if #(parameter int N = 6) ();
  localparam int IW = $clog2(N);
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  ptr;
  logic          preempt;
  modport master (output req, input gnt, gnt_valid, gnt_idx, ptr, preempt);
  modport slave  (input req, output gnt, gnt_valid, gnt_idx, ptr, preempt);
endinterface

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: registered round-robin arbiter with a rotating one-hot priority token
// Optional hold limit with forced rotation: define RING_RR_ARBITER_TIMEOUT_EN.
module ring_rr_arbiter #(
  parameter int N        = 6,
  parameter int HOLD_MAX = 8
) (
  input logic              clk,
  input logic              reset,
  ring_rr_arbiter_if.slave arb
);
  localparam int IW = $clog2(N);
  if (N < 2 || N > 16 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_cfg
    $error("ring_rr_arbiter: N or HOLD_MAX out of range");
  end
  typedef enum logic {IDLE, OWNED} state_t;
  state_t          r_state, w_nstate;
  logic [N-1:0]    r_gnt, r_ptr, w_oh;
  logic [IW-1:0]   r_idx, w_win;
  logic            r_valid;
  logic [2*N-1:0]  w_dbl;
  logic            w_hold, w_other, w_rel, w_load, w_to;
  // upper copy of req covers the wrap-around part of the scan
  always_comb begin
    w_dbl = {arb.req, arb.req & ~(r_ptr - N'(1))};
    w_win = '0;
    for (int j = 2*N-1; j >= 0; j--)
      if (w_dbl[j]) w_win = IW'(j >= N ? j - N : j);
  end
  assign w_oh    = N'(1) << w_win;
  assign w_hold  = r_valid & arb.req[r_idx];
  assign w_other = |(arb.req & ~r_gnt);
  always_comb begin
    w_rel    = ~w_hold;
    w_load   = w_rel ? |arb.req : w_to;
    w_nstate = (w_load || !w_rel) ? OWNED : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nstate;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= N'(1);
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_nstate == OWNED;
      if (w_load) begin
        r_gnt <= w_oh;
        r_idx <= w_win;
        r_ptr <= {w_oh[N-2:0], w_oh[N-1]};
      end else if (w_nstate == IDLE) begin
        r_gnt <= '0;
        r_idx <= '0;
      end
    end
  end
`ifdef RING_RR_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HMAX1 = 8'(HOLD_MAX - 1);
  logic [7:0] r_cnt;
  logic       r_pre;
  assign w_to = (r_cnt == HMAX1) && w_other;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_pre <= 1'b0;
    end else begin
      r_cnt <= w_load ? 8'd0 : (r_valid && r_cnt != HMAX1) ? r_cnt + 8'd1 : r_cnt;
      r_pre <= w_hold & w_to;
    end
  end
  assign arb.preempt = r_pre;
`else
  assign w_to        = 1'b0;
  assign arb.preempt = 1'b0;
`endif
  assign arb.gnt       = r_gnt;
  assign arb.gnt_valid = r_valid;
  assign arb.gnt_idx   = r_idx;
  assign arb.ptr       = r_ptr;
  logic w_unused;
  assign w_unused = w_other;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter: directed self-checking bench for ring_rr_arbiter (N=6, HOLD_MAX=4)
module tb_ring_rr_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  ring_rr_arbiter_if #(.N(6)) arb ();
  ring_rr_arbiter #(.N(6), .HOLD_MAX(4)) dut (.clk(clk), .reset(reset), .arb(arb));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask
  task automatic chk_all(input string tag, input logic [5:0] g, input logic [2:0] idx, input logic [5:0] p);
    chk({tag, ".gnt"}, 32'(arb.gnt), 32'(g));
    chk({tag, ".valid"}, 32'(arb.gnt_valid), 32'(|g));
    chk({tag, ".idx"}, 32'(arb.gnt_idx), 32'(idx));
    chk({tag, ".ptr"}, 32'(arb.ptr), 32'(p));
  endtask
  initial begin
    logic [5:0] e;
    arb.req = 6'b111111;
    reset = 1'b1;
    tick;
    tick;
    chk_all("reset", 6'b000000, 3'd0, 6'b000001);
    chk("reset.preempt", 32'(arb.preempt), 32'd0);
    reset = 1'b0;
    arb.req = 6'b001000;
    tick;
    chk_all("single", 6'b001000, 3'd3, 6'b010000);
    arb.req = 6'b000000;
    tick;
    chk_all("single_drop", 6'b000000, 3'd0, 6'b010000);
    tick;
    chk_all("idle_hold", 6'b000000, 3'd0, 6'b010000);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    arb.req = 6'b111111;
    for (int k = 0; k < 7; k++) begin
      tick;
      e = 6'b000001 << (k % 6);
      chk_all($sformatf("contend%0d", k), e, 3'(k % 6), {e[4:0], e[5]});
      arb.req = 6'b111111 & ~e;
    end
    arb.req = 6'b000000;
    tick;
    chk_all("idle_again", 6'b000000, 3'd0, 6'b000010);
    arb.req = 6'b010000;
    tick;
    chk_all("grant4", 6'b010000, 3'd4, 6'b100000);
    arb.req = 6'b000101;
    tick;
    chk_all("wrap", 6'b000001, 3'd0, 6'b000010);
    for (int c = 1; c <= 16; c++) begin
      tick;
`ifdef RING_RR_ARBITER_TIMEOUT_EN
      e = ((c / 4) % 2) ? 6'b000100 : 6'b000001;
      chk($sformatf("timeout%0d.gnt", c), 32'(arb.gnt), 32'(e));
      chk($sformatf("timeout%0d.preempt", c), 32'(arb.preempt), 32'(c % 4 == 0));
`else
      chk($sformatf("hold%0d.gnt", c), 32'(arb.gnt), 32'(6'b000001));
      chk($sformatf("hold%0d.preempt", c), 32'(arb.preempt), 32'd0);
`endif
    end
    arb.req = 6'b000100;
    tick;
    chk_all("owner2", 6'b000100, 3'd2, 6'b001000);
    tick;
    chk_all("owner2_hold", 6'b000100, 3'd2, 6'b001000);
    reset = 1'b1;
    tick;
    chk_all("mid_reset", 6'b000000, 3'd0, 6'b000001);
    chk("mid_reset.preempt", 32'(arb.preempt), 32'd0);
    reset = 1'b0;
    tick;
    chk_all("after_reset", 6'b000100, 3'd2, 6'b001000);
    arb.req = 6'b100100;
    tick;
    chk_all("ignore_other", 6'b000100, 3'd2, 6'b001000);
    arb.req = 6'b100001;
    tick;
    chk_all("handover5", 6'b100000, 3'd5, 6'b000001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
